// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width derivation and extended-pointer full/empty compares.
// Used by both the single-clock and dual-clock FIFO families.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int unsigned addr_w_of(input int unsigned depth);
    return clog2(depth);
  endfunction

  function automatic int unsigned cnt_w_of(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  // Pointers carry one extra wrap bit above addr_w address bits.
  function automatic logic ptr_full(input logic [31:0] wr_ptr,
                                    input logic [31:0] rd_ptr,
                                    input int unsigned addr_w);
    logic [31:0] diff;
    diff = (wr_ptr ^ rd_ptr) & ((32'd1 << (addr_w + 1)) - 32'd1);
    return diff == (32'd1 << addr_w);
  endfunction

  function automatic logic ptr_empty(input logic [31:0] wr_ptr,
                                     input logic [31:0] rd_ptr,
                                     input int unsigned addr_w);
    logic [31:0] diff;
    diff = (wr_ptr ^ rd_ptr) & ((32'd1 << (addr_w + 1)) - 32'd1);
    return diff == 32'd0;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port register array: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill level, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2,
  localparam int unsigned ADDR_W   = addr_w_of(DEPTH),
  localparam int unsigned CNT_W    = cnt_w_of(DEPTH)
) (
  input  logic              clk_a,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              clr_err_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              fifo_full_o,
  output logic              fifo_empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              full, empty;
  logic              wr_acc, rd_acc;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem_rdata;

  // Status comes only from registered pointers, so it is glitch-free.
  assign full   = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_W);
  assign empty  = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_W);
  assign count  = wr_ptr_q - rd_ptr_q;

  assign wr_acc = wr_en_i & ~full;
  assign rd_acc = rd_en_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Set has priority over clear when both occur on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en_i & full) begin
      ovf_d = 1'b1;
    end
    if (rd_en_i & empty) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk_a),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; forced to zero while empty so stale memory never leaks out.
  assign rd_data_o  = empty ? '0 : mem_rdata;
  assign rd_valid_o = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      rd_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

  assign fifo_full_o    = full;
  assign fifo_empty_o   = empty;
  assign almost_full_o  = (count >= AFULL_C);
  assign almost_empty_o = (count <= AEMPTY_C);
  assign count_o        = count;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed table, corner sequences and random traffic vs a queue model.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;

  logic          clk_a = 1'b0;
  logic          rst_n;
  logic          wr_en_i, rd_en_i, clr_err_i;
  logic [DW-1:0] wr_data_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o, fifo_full_o, fifo_empty_o;
  logic          almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic [4:0]    count_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ovf, m_unf, m_svalid;
  logic [DW-1:0] m_sdata;

  sync_fifo_param #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH)
  ) dut (
    .clk_a          (clk_a),
    .rst_n          (rst_n),
    .wr_en_i        (wr_en_i),
    .wr_data_i      (wr_data_i),
    .rd_en_i        (rd_en_i),
    .clr_err_i      (clr_err_i),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .fifo_full_o    (fifo_full_o),
    .fifo_empty_o   (fifo_empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_a = ~clk_a;

  typedef struct {
    logic          wr;
    logic [DW-1:0] wd;
    logic          rd;
    logic          clr;
    int            cnt;
    logic          unf;
    logic          sv;
    logic [DW-1:0] sd;
    logic          fv;
    logic [DW-1:0] fd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_svalid = 1'b0;
    m_sdata  = '0;
  endtask

  task automatic model_step(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic clr);
    int  sz;
    bit  full, empty;
    sz    = q.size();
    full  = (sz == DEPTH);
    empty = (sz == 0);
    m_ovf = (wr && full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (rd && empty) ? 1'b1 : (clr ? 1'b0 : m_unf);
    m_svalid = 1'b0;
    if (rd && !empty) begin
      m_sdata  = q.pop_front();
      m_svalid = 1'b1;
    end
    if (wr && !full) q.push_back(wd);
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ".count"}, 32'(count_o), 32'(sz));
    chk({tag, ".full"},  32'(fifo_full_o), 32'(sz == DEPTH));
    chk({tag, ".empty"}, 32'(fifo_empty_o), 32'(sz == 0));
    chk({tag, ".afull"}, 32'(almost_full_o), 32'(sz >= AF_TH));
    chk({tag, ".aempty"}, 32'(almost_empty_o), 32'(sz <= AE_TH));
    chk({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
    chk({tag, ".unf"},   32'(underflow_o), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".valid"}, 32'(rd_valid_o), 32'(sz != 0));
    chk({tag, ".data"},  32'(rd_data_o), (sz != 0) ? 32'(q[0]) : 32'd0);
`else
    chk({tag, ".valid"}, 32'(rd_valid_o), 32'(m_svalid));
    chk({tag, ".data"},  32'(rd_data_o), 32'(m_sdata));
`endif
  endtask

  task automatic step(input string tag, input logic wr, input logic [DW-1:0] wd,
                      input logic rd, input logic clr);
    wr_en_i   = wr;
    wr_data_i = wd;
    rd_en_i   = rd;
    clr_err_i = clr;
    @(posedge clk_a);
    #1;
    model_step(wr, wd, rd, clr);
    check_all(tag);
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    clr_err_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".count"},  32'(count_o), 32'd0);
    chk({tag, ".empty"},  32'(fifo_empty_o), 32'd1);
    chk({tag, ".full"},   32'(fifo_full_o), 32'd0);
    chk({tag, ".aempty"}, 32'(almost_empty_o), 32'd1);
    chk({tag, ".afull"},  32'(almost_full_o), 32'd0);
    chk({tag, ".valid"},  32'(rd_valid_o), 32'd0);
    chk({tag, ".data"},   32'(rd_data_o), 32'd0);
    chk({tag, ".ovf"},    32'(overflow_o), 32'd0);
    chk({tag, ".unf"},    32'(underflow_o), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    clr_err_i = 1'b0;
    wr_data_i = '0;
    model_reset();
    repeat (2) @(posedge clk_a);
    #1;
    check_reset_values("reset");
    @(negedge clk_a);
    rst_n = 1'b1;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Directed table: empty-edge handling and error set/clear priority
    tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA1};
    tbl[2] = '{1'b1, 8'hB2, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hA1, 1'b1, 8'hB2};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'hB2, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1, 1'b1, 1'b0, 8'hB2, 1'b1, 8'hC3};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'hC3, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 8'hC3, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'hC3, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      step("tbl", tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
      chk("tbl.count", 32'(count_o), 32'(tbl[i].cnt));
      chk("tbl.unf", 32'(underflow_o), 32'(tbl[i].unf));
`ifdef SYNC_FIFO_FWFT_EN
      chk("tbl.valid", 32'(rd_valid_o), 32'(tbl[i].fv));
      chk("tbl.data", 32'(rd_data_o), 32'(tbl[i].fd));
`else
      chk("tbl.valid", 32'(rd_valid_o), 32'(tbl[i].sv));
      chk("tbl.data", 32'(rd_data_o), 32'(tbl[i].sd));
`endif
    end

    // Fill to full, then overflow
    for (int i = 1; i <= DEPTH; i++) begin
      step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 2)  chk("fill.aempty2", 32'(almost_empty_o), 32'd1);
      if (i == 3)  chk("fill.aempty3", 32'(almost_empty_o), 32'd0);
      if (i == 13) chk("fill.afull13", 32'(almost_full_o), 32'd0);
      if (i == 14) chk("fill.afull14", 32'(almost_full_o), 32'd1);
      if (i == 15) chk("fill.full15", 32'(fifo_full_o), 32'd0);
      if (i == 16) chk("fill.full16", 32'(fifo_full_o), 32'd1);
    end
    step("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf.flag", 32'(overflow_o), 32'd1);
    chk("ovf.count", 32'(count_o), 32'd16);

    // Drain in order, then underflow and clear
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain.head", 32'(rd_data_o), 32'(i + 1));
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
`else
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain.data", 32'(rd_data_o), 32'(i + 1));
      chk("drain.valid", 32'(rd_valid_o), 32'd1);
`endif
    end
    chk("drain.empty", 32'(fifo_empty_o), 32'd1);
    step("unf", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf.flag", 32'(underflow_o), 32'd1);
    step("clr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.ovf", 32'(overflow_o), 32'd0);
    chk("clr.unf", 32'(underflow_o), 32'd0);

    // Pointer wrap-around
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step("wrap.wr", 1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step("wrap.rd", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("wrap.count", 32'(count_o), 32'd0);

    // Simultaneous read+write at mid, full and empty occupancy
    for (int i = 0; i < 8; i++) step("mid.fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("mid.rw", 1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("mid.count", 32'(count_o), 32'd8);
    end
    for (int i = 0; i < 8; i++) step("top.fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
    step("full.rw", 1'b1, 8'h5A, 1'b1, 1'b0);
    chk("full.rw.count", 32'(count_o), 32'd15);
    for (int i = 0; i < 15; i++) step("bot.drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("empty.rw", 1'b1, 8'hA5, 1'b1, 1'b0);
    chk("empty.rw.count", 32'(count_o), 32'd1);
    chk("empty.rw.unf", 32'(underflow_o), 32'd1);

    // Asynchronous reset at count 9
    for (int i = 0; i < 8; i++) step("pre.rst", 1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("pre.rst.count", 32'(count_o), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async.rst");
    repeat (2) @(posedge clk_a);
    #3;
    rst_n = 1'b1;
    step("post.rst", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("post.rst.valid", 32'(rd_valid_o), 32'd0);
    step("post.rst.wr", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("post.rst.rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic in phases with different fill bias
    for (int p = 0; p < 4; p++) begin
      int unsigned wr_pct, rd_pct;
      wr_pct = (p % 2 == 0) ? 75 : 30;
      rd_pct = (p % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 150; i++) begin
        step("rand",
             ($urandom_range(99) < wr_pct),
             8'($urandom),
             ($urandom_range(99) < rd_pct),
             ($urandom_range(99) < 5));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the next-generation buffer alongside the dual-clock FIFO and is used where producer and consumer share clk_a. It generalises width and depth and adds:
- fill-level output
- programmable almost-full / almost-empty flags
- sticky overflow and underflow error flags
- optional first-word-fall-through (FWFT) read mode

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AFULL_TH, 14, almost_full_o asserts when count >= AFULL_TH (1..DEPTH-1).
- AEMPTY_TH, 2, almost_empty_o asserts when count <= AEMPTY_TH (1..DEPTH-1).

Ports:
- clk_a  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  write request.
- wr_data_i  in  DATA_W  write data, sampled with wr_en_i.
- rd_en_i  in  1  read request (pop/acknowledge in FWFT mode).
- clr_err_i  in  1  synchronous clear of the sticky error flags.
- rd_data_o  out  DATA_W  read data.
- rd_valid_o  out  1  rd_data_o holds a newly popped word (FWFT: head is valid).
- fifo_full_o  out  1  count == DEPTH.
- fifo_empty_o  out  1  count == 0.
- almost_full_o  out  1  count >= AFULL_TH.
- almost_empty_o  out  1  count <= AEMPTY_TH.
- count_o  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a write was attempted while full.
- underflow_o  out  1  sticky: a read was attempted while empty.

Behaviour:
- ADDR_W = clog2(DEPTH). Pointers are ADDR_W+1 bits (extra wrap bit); full = MSBs differ and address bits equal; empty = pointers equal. Address wraps from DEPTH-1 to 0.
- Reset (rst_n low, asynchronous): pointers=0, count_o=0, rd_data_o=0, rd_valid_o=0, fifo_empty_o=1, fifo_full_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0. Memory contents are not reset.
- Reset released mid-operation: the FIFO is empty; there is no residual data and no spurious rd_valid_o.
- Write accepted = wr_en_i & ~fifo_full_o. The write is stored at wr_ptr and wr_ptr increments on the same edge.
- Read accepted = rd_en_i & ~fifo_empty_o.
- Full and empty are evaluated on pre-edge state:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: count_o is unchanged and both pointers advance.
- count_o, fifo_full_o, fifo_empty_o, almost_* are all registered or derived only from registered pointers/count, so they are glitch-free and update the cycle after the accepted operation.
- Error flags:
  - overflow_o sets on the edge where wr_en_i & fifo_full_o.
  - underflow_o sets on the edge where rd_en_i & fifo_empty_o.
  - Both hold until clr_err_i=1 at an edge. If set and clear coincide, set wins.
- Rejected operations do not change pointers, count or data outputs.
- Standard read mode (macro undefined):
  - rd_data_o is registered: mem[rd_ptr] appears one cycle after an accepted read.
  - rd_valid_o pulses high for exactly that cycle.
  - rd_data_o holds its last value otherwise.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN.
- Defined:
  - rd_data_o = mem[rd_ptr] combinationally whenever the FIFO is non-empty; rd_valid_o = ~fifo_empty_o.
  - rd_en_i acts as an acknowledge: an accepted read advances rd_ptr, and the next head appears in the same cycle as the pointer update.
  - A word written into an empty FIFO is visible on rd_data_o the cycle after the write edge.
  - Flags and count behave identically to standard mode.
- Undefined: standard 1-cycle registered read as described in Behaviour.

Decomposition:
- Shared package/header fifo_pkg:
  - clog2 function
  - derived ADDR_W / CNT_W width constants
  - pointer-compare helpers (full/empty from extended pointers)
  - also reused by the dual-clock FIFO.
- One natural sub-module: fifo_mem, a DEPTH x DATA_W simple dual-port register array with synchronous write and asynchronous read. The FIFO top adds the output register in standard mode.

Test Plan (DATA_W=8, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2):
- Reset then idle -> fifo_empty_o=1, almost_empty_o=1, count_o=0, rd_valid_o=0, errors=0.
- Write 0x01..0x10 (16 writes) -> count_o 1..16; almost_empty_o drops at count 3; almost_full_o rises at 14; fifo_full_o=1 at 16. A 17th write sets overflow_o=1 and count_o stays 16.
- Read 16 words -> rd_data_o sequence 0x01..0x10, each one cycle after its rd_en_i (same cycle under SYNC_FIFO_FWFT_EN); fifo_empty_o=1; an extra read sets underflow_o; clr_err_i clears both error flags.
- Wrap-around: write 10 and read 10 words, three times -> data in order across the pointer wrap, final count_o=0.
- Simultaneous read+write at count 8 for 20 cycles -> count_o stays 8 and output order is preserved. At count 16, read+write -> only the read is accepted and count_o becomes 15. At count 0, read+write -> only the write is accepted and count_o becomes 1.
- Assert rst_n low at count 9 -> all outputs return to reset values immediately (asynchronous), and after release the FIFO behaves as empty.
